// File: rtl/if_id_stage_pkg.sv
// ============================================================================
// if_id_stage_pkg : shared widths, bubble encoding and IF/ID skid state type
// Revision 1.0
// ============================================================================
`default_nettype none

package if_id_stage_pkg;

  localparam int DATA_W = 16;
  localparam logic [DATA_W-1:0] NOP_INSTR = 16'h0800;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } ifid_state_e;

endpackage

`default_nettype wire

// File: rtl/if_id_stage.sv
// ============================================================================
// if_id_stage : IF/ID pipeline register with stall, flush, bubble insertion
//               and a one-entry skid register for words fetched during stall
// Revision 1.0
// ============================================================================
`default_nettype none

module if_id_stage
  import if_id_stage_pkg::*;
(
  input  logic              ifi_clk,
  input  logic              ifi_rst,
  input  logic [DATA_W-1:0] ifi_pc,
  input  logic [DATA_W-1:0] ifi_instr,
  input  logic              ifi_fetch_valid,
  input  logic              ifi_ram2_busy,
  input  logic              ifi_stall,
  input  logic              ifi_flush,
  output logic [DATA_W-1:0] ifo_pc,
  output logic [DATA_W-1:0] ifo_pc_plus1,
  output logic [DATA_W-1:0] ifo_instr,
  output logic              ifo_valid,
  output logic              ifo_keep,
  output logic [15:0]       ifo_fetch_cnt
);

  ifid_state_e       state_q, state_d;
  logic [DATA_W-1:0] skid_pc_q, skid_pc_d;
  logic [DATA_W-1:0] skid_instr_q, skid_instr_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] pc_plus1_q, pc_plus1_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              w_take;

  assign w_take = ifi_fetch_valid & ~ifi_ram2_busy;

  always_comb begin
    state_d      = state_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    pc_d         = pc_q;
    pc_plus1_d   = pc_plus1_q;
    instr_d      = instr_q;
    valid_d      = valid_q;
    cnt_d        = cnt_q;

    if (ifi_flush) begin
      instr_d      = NOP_INSTR;
      valid_d      = 1'b0;
      skid_pc_d    = '0;
      skid_instr_d = NOP_INSTR;
      state_d      = ST_RUN;
    end else if (ifi_stall) begin
      // Park the word fetch is presenting so the PC can be held without losing it.
      if (state_q == ST_RUN && w_take) begin
        skid_pc_d    = ifi_pc;
        skid_instr_d = ifi_instr;
        state_d      = ST_HOLD;
      end
    end else if (state_q == ST_HOLD) begin
      pc_d       = skid_pc_q;
      pc_plus1_d = skid_pc_q + DATA_W'(1);
      instr_d    = skid_instr_q;
      valid_d    = 1'b1;
      cnt_d      = cnt_q + 16'd1;
      state_d    = ST_RUN;
    end else if (w_take) begin
      pc_d       = ifi_pc;
      pc_plus1_d = ifi_pc + DATA_W'(1);
      instr_d    = ifi_instr;
      valid_d    = 1'b1;
      cnt_d      = cnt_q + 16'd1;
    end else begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge ifi_clk) begin
    if (ifi_rst) begin
      state_q      <= ST_RUN;
      skid_pc_q    <= '0;
      skid_instr_q <= NOP_INSTR;
      pc_q         <= '0;
      pc_plus1_q   <= DATA_W'(1);
      instr_q      <= NOP_INSTR;
      valid_q      <= 1'b0;
      cnt_q        <= 16'd0;
    end else begin
      state_q      <= state_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      pc_q         <= pc_d;
      pc_plus1_q   <= pc_plus1_d;
      instr_q      <= instr_d;
      valid_q      <= valid_d;
      cnt_q        <= cnt_d;
    end
  end

  // A flush lets fetch redirect immediately, so keep is suppressed.
  assign ifo_keep      = ~ifi_flush & (ifi_stall | (state_q == ST_HOLD) | ifi_ram2_busy);
  assign ifo_pc        = pc_q;
  assign ifo_pc_plus1  = pc_plus1_q;
  assign ifo_instr     = instr_q;
  assign ifo_valid     = valid_q;
  assign ifo_fetch_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_if_id_stage.sv
// ============================================================================
// tb_if_id_stage : directed scoreboard bench for the IF/ID pipeline register
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst, fv, busy, stall, flush;
  logic [15:0] pc_in, instr_in;
  logic [15:0] o_pc, o_pc1, o_instr, o_cnt;
  logic        o_valid, o_keep;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] pc1;
    logic [15:0] instr;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] prev_cnt = 16'd0;

  always #5 clk = ~clk;

  if_id_stage dut (
    .ifi_clk         (clk),
    .ifi_rst         (rst),
    .ifi_pc          (pc_in),
    .ifi_instr       (instr_in),
    .ifi_fetch_valid (fv),
    .ifi_ram2_busy   (busy),
    .ifi_stall       (stall),
    .ifi_flush       (flush),
    .ifo_pc          (o_pc),
    .ifo_pc_plus1    (o_pc1),
    .ifo_instr       (o_instr),
    .ifo_valid       (o_valid),
    .ifo_keep        (o_keep),
    .ifo_fetch_cnt   (o_cnt)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a new ID word is one that is valid and advanced the accept count.
  always @(posedge clk) begin
    #1;
    if (!rst && o_valid && o_cnt != prev_cnt) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected: got pc=%h instr=%h with no expected word", o_pc, o_instr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({o_pc, o_pc1, o_instr, o_cnt} !== e) begin
          n_bad++;
          $display("FAIL sb_word: got pc=%h pc1=%h instr=%h cnt=%h expected pc=%h pc1=%h instr=%h cnt=%h",
                   o_pc, o_pc1, o_instr, o_cnt, e.pc, e.pc1, e.instr, e.cnt);
        end
        n_cmp++;
      end
    end
    prev_cnt = o_cnt;
  end

  // Apply one cycle of inputs at the falling edge; the next rising edge consumes them.
  task automatic drive(input logic r, input logic v, input logic b, input logic s,
                       input logic f, input logic [15:0] p, input logic [15:0] i);
    @(negedge clk);
    rst = r; fv = v; busy = b; stall = s; flush = f; pc_in = p; instr_in = i;
    #1;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [15:0] p, input logic [15:0] i, input logic [15:0] c);
    sb.push_back({p, p + 16'd1, i, c});
  endtask

  initial begin
    rst = 1'b1; fv = 1'b0; busy = 1'b0; stall = 1'b0; flush = 1'b0;
    pc_in = 16'd0; instr_in = 16'd0;

    // Reset
    drive(1, 0, 0, 0, 0, 16'd0, 16'd0);
    after_edge();
    chk("rst_pc", o_pc, 16'h0000);
    chk("rst_pc1", o_pc1, 16'h0001);
    chk("rst_instr", o_instr, 16'h0800);
    chk("rst_valid", {15'd0, o_valid}, 16'd0);
    chk("rst_cnt", o_cnt, 16'd0);
    chk("rst_keep", {15'd0, o_keep}, 16'd0);

    // Three back-to-back fetches
    push(16'd0, 16'hA000, 16'd1); drive(0, 1, 0, 0, 0, 16'd0, 16'hA000);
    push(16'd1, 16'hB000, 16'd2); drive(0, 1, 0, 0, 0, 16'd1, 16'hB000);
    push(16'd2, 16'hC000, 16'd3); drive(0, 1, 0, 0, 0, 16'd2, 16'hC000);
    after_edge();
    chk("t1_cnt", o_cnt, 16'd3);
    chk("t1_pc1", o_pc1, 16'd3);

    // Stall two cycles with pc=5 pending, RAM2 lent on the second
    drive(0, 1, 0, 1, 0, 16'd5, 16'h5555);
    chk("t2_keep_s1", {15'd0, o_keep}, 16'd1);
    drive(0, 1, 1, 1, 0, 16'd5, 16'hDEAD);
    chk("t2_keep_s2", {15'd0, o_keep}, 16'd1);
    chk("t2_hold_instr", o_instr, 16'hC000);
    push(16'd5, 16'h5555, 16'd4);
    drive(0, 1, 0, 0, 0, 16'd5, 16'h5555);
    chk("t2_keep_hold", {15'd0, o_keep}, 16'd1);
    after_edge();
    chk("t2_rel_pc", o_pc, 16'd5);
    chk("t2_rel_instr", o_instr, 16'h5555);
    push(16'd6, 16'h6666, 16'd5);
    drive(0, 1, 0, 0, 0, 16'd6, 16'h6666);
    chk("t2_keep_run", {15'd0, o_keep}, 16'd0);
    after_edge();
    chk("t2_next_pc", o_pc, 16'd6);

    // Advance while RAM2 is busy: bubble
    drive(0, 1, 1, 0, 0, 16'd7, 16'hBAD0);
    chk("t3_keep", {15'd0, o_keep}, 16'd1);
    after_edge();
    chk("t3_instr", o_instr, 16'h0800);
    chk("t3_valid", {15'd0, o_valid}, 16'd0);
    chk("t3_cnt", o_cnt, 16'd5);
    chk("t3_pc_hold", o_pc, 16'd6);

    // Flush + stall while HOLD: skid word dropped
    drive(0, 1, 0, 1, 0, 16'd7, 16'h7777);
    drive(0, 1, 0, 1, 1, 16'd7, 16'h7777);
    chk("t4_keep_flush", {15'd0, o_keep}, 16'd0);
    after_edge();
    chk("t4_instr", o_instr, 16'h0800);
    chk("t4_valid", {15'd0, o_valid}, 16'd0);
    chk("t4_pc_hold", o_pc, 16'd6);
    drive(0, 0, 0, 0, 0, 16'd0, 16'd0);
    chk("t4_keep_run", {15'd0, o_keep}, 16'd0);
    after_edge();
    chk("t4_no_skid", {15'd0, o_valid}, 16'd0);
    push(16'd20, 16'h2020, 16'd6);
    drive(0, 1, 0, 0, 0, 16'd20, 16'h2020);
    after_edge();

    // Reset while HOLD
    drive(0, 1, 0, 1, 0, 16'd30, 16'h3030);
    drive(1, 1, 0, 1, 0, 16'd30, 16'h3030);
    after_edge();
    chk("t5_pc", o_pc, 16'h0000);
    chk("t5_pc1", o_pc1, 16'h0001);
    chk("t5_instr", o_instr, 16'h0800);
    chk("t5_valid", {15'd0, o_valid}, 16'd0);
    chk("t5_cnt", o_cnt, 16'd0);
    drive(0, 0, 0, 0, 0, 16'd0, 16'd0);
    chk("t5_keep", {15'd0, o_keep}, 16'd0);
    after_edge();
    chk("t5_skid_gone", {15'd0, o_valid}, 16'd0);

    // Counter and pc_plus1 wrap
    for (int k = 0; k < 65535; k++) begin
      push(16'(k), 16'(k ^ 16'h5A5A), 16'(k + 1));
      drive(0, 1, 0, 0, 0, 16'(k), 16'(k ^ 16'h5A5A));
    end
    push(16'hFFFF, 16'h1234, 16'h0000);
    drive(0, 1, 0, 0, 0, 16'hFFFF, 16'h1234);
    after_edge();
    chk("t6_cnt_wrap", o_cnt, 16'h0000);
    chk("t6_pc1_wrap", o_pc1, 16'h0000);
    chk("t6_pc", o_pc, 16'hFFFF);

    drive(0, 0, 0, 0, 0, 16'd0, 16'd0);
    after_edge();
    after_edge();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: got %0d words never seen, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
